// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Owns the program counter, issues reads to a
//   synchronous program memory (one-cycle read latency) and buffers the
//   returned words, tagged with their fetch address, in a small prefetch FIFO.
//   The FIFO head is offered to the decoder over a valid/ready handshake.
//   A jump flushes the FIFO and the in-flight read and redirects the PC;
//   halt stops new reads while letting the in-flight read and FIFO drain.
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   adds stall_cnt / flush_cnt saturating 16-bit performance counters.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active low
//   prog_rd_en   out  program memory read strobe
//   prog_addr    out  program memory word address (the PC register)
//   prog_data    in   read data, valid one cycle after prog_rd_en
//   instr        out  FIFO head instruction word (0 when empty)
//   instr_pc     out  fetch address of the head word (0 when empty)
//   instr_valid  out  FIFO head present
//   instr_ready  in   consumer accepts the head this cycle
//   jump_en      in   redirect pulse
//   jump_addr    in   redirect target
//   stall_cnt    out  cycles with instr_valid && !instr_ready (optional)
//   flush_cnt    out  number of jumps seen (optional)
//   halt         in   level, suppresses new reads
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int PROG_ADDR_WIDTH = 8,
    parameter int INSTR_WIDTH     = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       prog_rd_en,
    output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]     prog_data,
    output logic [INSTR_WIDTH-1:0]     instr,
    output logic [PROG_ADDR_WIDTH-1:0] instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    input  logic                       jump_en,
    input  logic [PROG_ADDR_WIDTH-1:0] jump_addr,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]                stall_cnt,
    output logic [15:0]                flush_cnt,
`endif
    input  logic                       halt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PROG_ADDR_WIDTH-1:0] pc_p0;
    logic                       vld_p1;
    logic [PROG_ADDR_WIDTH-1:0] tag_p1;
    logic [CNT_W-1:0]           count;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W-1:0]           wr_ptr;
    logic [INSTR_WIDTH-1:0]     data_mem [FIFO_DEPTH];
    logic [PROG_ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic                       credit;
    logic                       issue;
    logic                       push;
    logic                       pop;

    // A read is only issued when the FIFO is guaranteed room for its response,
    // counting the one possibly still in flight. Uses registered state only,
    // so a same-cycle pop does not free credit until the next cycle.
    assign credit = (count + CNT_W'(vld_p1)) < CNT_W'(FIFO_DEPTH);
    assign issue  = rst && !halt && !jump_en && credit;
    // A jump voids both the arriving response and any pop in that cycle.
    assign push   = rst && vld_p1 && !jump_en;
    assign pop    = rst && instr_valid && instr_ready && !jump_en;

    assign prog_rd_en  = issue;
    assign prog_addr   = pc_p0;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

    // Stage p0 -> p1: PC advances on issue, read is marked in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_p0  <= '0;
            vld_p1 <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (jump_en) begin
            pc_p0  <= jump_addr;
            vld_p1 <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) pc_p0 <= pc_p0 + PROG_ADDR_WIDTH'(1);
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Stage p1 -> FIFO: response word and its fetch address are stored together
    always_ff @(posedge clk) begin
        if (issue) tag_p1 <= pc_p0;
        if (push) begin
            data_mem[wr_ptr] <= prog_data;
            pc_mem[wr_ptr]   <= tag_p1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (instr_valid && !instr_ready) stall_cnt <= sat_inc(stall_cnt);
            if (jump_en)                     flush_cnt <= sat_inc(flush_cnt);
        end
    end
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of `proc`: owns the program counter, reads 32-bit instruction words from a synchronous program memory and buffers them in a small prefetch FIFO. It hands words to `proc`'s decode logic over a valid/ready handshake, so memory latency and decode back-pressure stay decoupled. It supports PC redirect (jump/branch) with full flush, and a halt input that stops further fetching.

## Interface
- `PROG_ADDR_WIDTH`, 8, program memory word-address width; PC width.
- `INSTR_WIDTH`, 32, instruction word width.
- `FIFO_DEPTH`, 4, prefetch buffer entries; power of two, at least 2.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `prog_rd_en`  out  1  program memory read strobe.
- `prog_addr`  out  PROG_ADDR_WIDTH  read address; equals PC register.
- `prog_data`  in  INSTR_WIDTH  read data, valid exactly one cycle after `prog_rd_en`.
- `instr`  out  INSTR_WIDTH  FIFO head word.
- `instr_pc`  out  PROG_ADDR_WIDTH  address the head word was fetched from.
- `instr_valid`  out  1  head entry present.
- `instr_ready`  in  1  consumer accepts head this cycle.
- `jump_en`  in  1  redirect request, one-cycle pulse.
- `jump_addr`  in  PROG_ADDR_WIDTH  redirect target.
- `halt`  in  1  level; suppresses new reads while high.

## Operation
- Reset (`rst`=0 at an edge): PC=0, FIFO empty, in-flight flag cleared, `prog_rd_en`=0, `prog_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0.
- Issue rule: `prog_rd_en` = !halt && !jump_en && (count + inflight < FIFO_DEPTH), using registered count and inflight. A pop in the same cycle does not free credit until the next cycle.
- On issue: inflight<=1, tag<=PC, PC<=PC+1, wrapping modulo 2^PROG_ADDR_WIDTH (0xFF -> 0x00).
- Capture: in the cycle after an issue, `prog_data` and the tag are pushed into the FIFO.
- Pop: occurs when `instr_valid && instr_ready`. `instr_ready` without valid is ignored.
- Push and pop may occur in the same cycle. Count then stays unchanged. Overflow is impossible by the credit rule.
- Redirect (`jump_en`=1), highest priority:
  - FIFO is cleared; any pop in that cycle is void.
  - Inflight is cleared, and the response arriving the next cycle is discarded.
  - PC<=jump_addr; no read is issued that cycle.
  - Fetch resumes from jump_addr the following cycle unless halted.
- Halt: no new issues. An in-flight read still completes and is pushed. The FIFO drains normally. Deasserting halt resumes from the current PC.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

## Timing
- Issue at cycle N -> `prog_data` valid cycle N+1 -> `instr_valid` high at cycle N+2. There is no bypass.
- First read after reset release: `prog_rd_en`=1, `prog_addr`=0 in the first cycle with `rst` high.
- With `instr_ready` held high, the sustained rate is one instruction per cycle once the pipeline fills.
- Jump at cycle J: `instr_valid`=0 at J+1. First redirected word is issued at J+1, valid at J+3.
- Outputs `instr`, `instr_pc` and `instr_valid` are driven from registers or FIFO storage, never combinationally from `prog_data`.
- Reset asserted mid-operation clears everything at that edge. In-flight data returning afterwards is discarded.

## Configuration
- `FETCH_PERF_CNT_EN`:
  - Defined: adds output `stall_cnt` (16 bits, reset 0). It increments, saturating at 0xFFFF, every cycle `instr_valid`=1 and `instr_ready`=0. It also adds `flush_cnt` (16 bits, reset 0), incremented on each `jump_en`, saturating.
  - Undefined: neither port nor its logic exists. Fetch behaviour is identical in both cases.

## Test plan
- Reset then run, memory word k = 0xA000_0000+k, `instr_ready`=1 -> `instr_valid` rises on the 3rd cycle after reset release. The bench receives 0xA0000000, 0xA0000001, … with `instr_pc` 0,1,2… in consecutive cycles.
- `instr_ready`=0 for 10 cycles -> exactly 4 reads issued, FIFO full, `prog_rd_en`=0. Releasing ready then delivers PC 0–3 in order with no loss or duplication.
- `jump_en` with `jump_addr`=0x40 while FIFO holds 3 entries and a read is in flight -> next delivered word has `instr_pc`=0x40. No stale word is delivered.
- Start PC at 0xFE via jump -> delivered `instr_pc` sequence is 0xFE, 0xFF, 0x00, 0x01.
- `halt`=1 for 5 cycles with `instr_ready`=1 -> `prog_rd_en` stays 0 and the FIFO drains. After `halt`=0, fetch continues at the next sequential PC.
- Under `FETCH_PERF_CNT_EN`: 7 stalled-valid cycles plus 2 jumps -> `stall_cnt`=7, `flush_cnt`=2.
